// File: rtl/shift_add_multiplier_pkg.sv
// Shared encodings and sizes for the sequential shift-and-add multiplier.
// The state encodings and handshake levels are shared with the core controller.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    localparam int MUL_WIDTH        = 8;
    localparam int MUL_RESULT_WIDTH = 18;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/shift_add_multiplier_negate.sv
// Conditional two's-complement negation of a W-bit value.
// Used for the operand magnitudes and for the final sign fix-up of the product.
module twos_complement_negate #(
    parameter int W = 8
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential WIDTH x WIDTH shift-and-add multiplier with an enable/busy/done handshake.
// Signed operands are reduced to magnitudes and the sign is reapplied on the final iteration.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH        = MUL_WIDTH,
    parameter int RESULT_WIDTH = MUL_RESULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    signedMode,
    input  logic [WIDTH-1:0]        operand_1,
    input  logic [WIDTH-1:0]        operand_2,
    output logic [RESULT_WIDTH-1:0] product,
    output logic                    busy,
    output logic                    done
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_t       state, state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mag_1, mag_2, mplier;
    logic [PW-1:0]    mcand, acc, acc_next, acc_fixed;
    logic             neg_result, signed_latched;
    logic             start, last;

    // Sign handling: the product is at most 16 bits, so only the extension differs by mode.
    function automatic logic [RESULT_WIDTH-1:0] extend_result(input logic [PW-1:0] v,
                                                              input logic          sgn);
        extend_result = {{(RESULT_WIDTH - PW){sgn & v[PW-1]}}, v};
    endfunction

    twos_complement_negate #(.W(WIDTH)) u_mag_1 (
        .value  (operand_1),
        .negate (signedMode & operand_1[WIDTH-1]),
        .result (mag_1)
    );

    twos_complement_negate #(.W(WIDTH)) u_mag_2 (
        .value  (operand_2),
        .negate (signedMode & operand_2[WIDTH-1]),
        .result (mag_2)
    );

    twos_complement_negate #(.W(PW)) u_fix_sign (
        .value  (acc_next),
        .negate (neg_result),
        .result (acc_fixed)
    );

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= MUL_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        last       = 1'b0;
        case (state)
            MUL_IDLE: begin
                if (enable == ENABLE) begin
                    start      = 1'b1;
                    state_next = MUL_RUN;
                end
            end
            MUL_RUN: begin
                if (count == CNT_W'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = MUL_DONE;
                end
            end
            MUL_DONE: state_next = MUL_IDLE;
            default:  state_next = MUL_IDLE;
        endcase
    end

    // Iteration datapath: needs no reset, it is always reloaded at start.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand          <= {{WIDTH{1'b0}}, mag_1};
            mplier         <= mag_2;
            acc            <= '0;
            neg_result     <= signedMode & (operand_1[WIDTH-1] ^ operand_2[WIDTH-1]);
            signed_latched <= signedMode;
        end else if (state == MUL_RUN) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            product <= '0;
        end else begin
            if (start)                  count <= '0;
            else if (state == MUL_RUN)  count <= count + CNT_W'(1);
            if (last)                   product <= extend_result(acc_fixed, signed_latched);
        end
    end

    assign busy = (state == MUL_RUN);
    assign done = (state == MUL_DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (8x8, 18-bit product).
module tb_shift_add_multiplier;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        signedMode;
    logic [7:0]  operand_1;
    logic [7:0]  operand_2;
    logic [17:0] product;
    logic        busy;
    logic        done;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cycle     = 0;

    shift_add_multiplier #(.WIDTH(8), .RESULT_WIDTH(18)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .signedMode (signedMode),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .product    (product),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Drive a one-cycle start; returns #1 after the sampling edge E0.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s);
        @(negedge clk);
        enable = 1'b1; operand_1 = a; operand_2 = b; signedMode = s;
        @(posedge clk); #1;
        enable = 1'b0; operand_1 = 8'hXX; operand_2 = 8'hXX; signedMode = 1'b0;
    endtask

    // Called #1 after E0; returns #1 after the edge that raises done (bounded).
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0; busy_cycles = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; signedMode = 1'b0; operand_1 = '0; operand_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (product !== 18'd0) $display("FAIL reset_product got %h want 0", product); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic [17:0] ve [3];
        int lat, bc;
        va[0] = 8'd13;  vb[0] = 8'd11;  ve[0] = 18'd143;
        va[1] = 8'd255; vb[1] = 8'd255; ve[1] = 18'd65025;
        va[2] = 8'd0;   vb[2] = 8'd200; ve[2] = 18'd0;
        for (int i = 0; i < 3; i++) begin
            start_op(va[i], vb[i], 1'b0);
            wait_done(lat, bc);
            total_cnt++; if (product !== ve[i]) $display("FAIL unsigned_%0d product got %0d want %0d", i, product, ve[i]); else pass_cnt++;
            total_cnt++; if (lat != 8) $display("FAIL unsigned_%0d latency got %0d want 8", i, lat); else pass_cnt++;
            total_cnt++; if (bc != 8) $display("FAIL unsigned_%0d busy_cycles got %0d want 8", i, bc); else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++; if (done !== 1'b0) $display("FAIL unsigned_%0d done_pulse got %b want 0", i, done); else pass_cnt++;
        end
    endtask

    task automatic test_signed();
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic [17:0] ve [3];
        int lat, bc;
        va[0] = 8'hFD; vb[0] = 8'h05; ve[0] = 18'h3FFF1;
        va[1] = 8'h80; vb[1] = 8'h80; ve[1] = 18'd16384;
        va[2] = 8'hFF; vb[2] = 8'hFF; ve[2] = 18'd1;
        for (int i = 0; i < 3; i++) begin
            start_op(va[i], vb[i], 1'b1);
            wait_done(lat, bc);
            total_cnt++; if (product !== ve[i]) $display("FAIL signed_%0d product got %h want %h", i, product, ve[i]); else pass_cnt++;
            total_cnt++; if (lat != 8) $display("FAIL signed_%0d latency got %0d want 8", i, lat); else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_enable_held();
        int lat, bc;
        start_op(8'd7, 8'd6, 1'b0);
        enable = 1'b1; operand_1 = 8'd9; operand_2 = 8'd9;
        wait_done(lat, bc);
        total_cnt++; if (product !== 18'd42) $display("FAIL held_first product got %0d want 42", product); else pass_cnt++;
        total_cnt++; if (lat != 8) $display("FAIL held_first latency got %0d want 8", lat); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL held_idle_gap busy got %b want 0", busy); else pass_cnt++;
        @(posedge clk); #1;
        enable = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL held_second_start busy got %b want 1", busy); else pass_cnt++;
        wait_done(lat, bc);
        total_cnt++; if (product !== 18'd81) $display("FAIL held_second product got %0d want 81", product); else pass_cnt++;
        total_cnt++; if (lat != 8) $display("FAIL held_second latency got %0d want 8", lat); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_run_reset();
        int lat, bc, done_seen;
        start_op(8'd200, 8'd200, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (product !== 18'd0) $display("FAIL midreset_product got %0d want 0", product); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL midreset_done got %b want 0", done); else pass_cnt++;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        total_cnt++; if (done_seen != 0) $display("FAIL midreset_no_activity got %0d want 0", done_seen); else pass_cnt++;
        start_op(8'd2, 8'd3, 1'b0);
        wait_done(lat, bc);
        total_cnt++; if (product !== 18'd6 || lat != 8) $display("FAIL midreset_recover product %0d lat %0d want 6 lat 8", product, lat); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, bc, c1, c2;
        start_op(8'd3, 8'd4, 1'b0);
        wait_done(lat, bc);
        c1 = cycle;
        total_cnt++; if (product !== 18'd12) $display("FAIL b2b_first product got %0d want 12", product); else pass_cnt++;
        @(posedge clk); #1;
        start_op(8'd5, 8'd6, 1'b0);
        wait_done(lat, bc);
        c2 = cycle;
        total_cnt++; if (product !== 18'd30) $display("FAIL b2b_second product got %0d want 30", product); else pass_cnt++;
        total_cnt++; if (c2 - c1 != 10) $display("FAIL b2b_spacing got %0d want 10", c2 - c1); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_enable_held();
        test_mid_run_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
